// File: rtl/instr_exec_unit.sv
// Instruction execution unit: walks a contiguous block of instruction-register
// locations, executes each instruction and presents one signed result per
// instruction on a valid/ready channel.
module instr_exec_unit #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned OP_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W:0]       count,
  output logic [ADDR_W-1:0]     read_pointer,
  input  logic [4+2*OP_W-1:0]   instruction_word,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2*OP_W-1:0]     result,
  output logic [ADDR_W-1:0]     res_addr,
  output logic [3:0]            res_opc,
  output logic                  div_by_zero,
  output logic                  illegal_op,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned RES_W = 2 * OP_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef struct packed {
    logic [3:0]      opc;
    logic [OP_W-1:0] op_a;
    logic [OP_W-1:0] op_b;
  } instruction_t;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, OUT} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   remaining, remaining_nx;
  logic [ADDR_W-1:0]  read_pointer_nx;
  logic [3:0]         opc_q, opc_nx;
  logic [OP_W-1:0]    op_a_q, op_a_nx;
  logic [OP_W-1:0]    op_b_q, op_b_nx;
  logic [RES_W-1:0]   result_nx;
  logic [ADDR_W-1:0]  res_addr_nx;
  logic [3:0]         res_opc_nx;
  logic               res_valid_nx, div_by_zero_nx, illegal_op_nx;
  logic               busy_nx, done_nx;

  instruction_t       instr_c;
  logic [RES_W-1:0]   exec_result_c;
  logic               exec_dz_c, exec_ill_c;

  logic signed [RES_W-1:0] a_ext, b_ext, b_div, quot, rem, prod;

  assign instr_c = instruction_t'(instruction_word);

  // Signed arithmetic on the captured instruction; divisor forced nonzero so
  // the divider never sees zero (the flag path overrides the result instead).
  always_comb begin
    a_ext         = {{OP_W{op_a_q[OP_W-1]}}, op_a_q};
    b_ext         = {{OP_W{op_b_q[OP_W-1]}}, op_b_q};
    b_div         = (op_b_q == '0) ? RES_W'(1) : b_ext;
    quot          = a_ext / b_div;
    rem           = a_ext % b_div;
    prod          = a_ext * b_ext;
    exec_result_c = '0;
    exec_dz_c     = 1'b0;
    exec_ill_c    = 1'b0;
    case (opc_q)
      4'd0: exec_result_c = '0;
      4'd1: exec_result_c = a_ext;
      4'd2: exec_result_c = b_ext;
      4'd3: exec_result_c = a_ext + b_ext;
      4'd4: exec_result_c = a_ext - b_ext;
      4'd5: exec_result_c = prod;
      4'd6: begin
        exec_dz_c     = (op_b_q == '0);
        exec_result_c = exec_dz_c ? '0 : quot;
      end
      4'd7: begin
        exec_dz_c     = (op_b_q == '0);
        exec_result_c = exec_dz_c ? '0 : rem;
      end
      default: begin
        exec_result_c = '0;
        exec_ill_c    = 1'b1;
      end
    endcase
  end

  // Next-state and registered-output logic. A start arriving while done is
  // still high is ignored so a new block begins no earlier than after done.
  always_comb begin
    state_nx        = state;
    remaining_nx    = remaining;
    read_pointer_nx = read_pointer;
    opc_nx          = opc_q;
    op_a_nx         = op_a_q;
    op_b_nx         = op_b_q;
    result_nx       = result;
    res_addr_nx     = res_addr;
    res_opc_nx      = res_opc;
    res_valid_nx    = res_valid;
    div_by_zero_nx  = div_by_zero;
    illegal_op_nx   = illegal_op;
    done_nx         = 1'b0;
    case (state)
      IDLE: begin
        if (start && !done) begin
          if (count != '0) begin
            remaining_nx    = count;
            read_pointer_nx = start_addr;
            state_nx        = FETCH;
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      FETCH: begin
        opc_nx   = instr_c.opc;
        op_a_nx  = instr_c.op_a;
        op_b_nx  = instr_c.op_b;
        state_nx = EXEC;
      end
      EXEC: begin
        result_nx      = exec_result_c;
        div_by_zero_nx = exec_dz_c;
        illegal_op_nx  = exec_ill_c;
        res_addr_nx    = read_pointer;
        res_opc_nx     = opc_q;
        res_valid_nx   = 1'b1;
        state_nx       = OUT;
      end
      OUT: begin
        if (res_ready) begin
          remaining_nx = remaining - CNT_W'(1);
          res_valid_nx = 1'b0;
          if (remaining == CNT_W'(1)) begin
            done_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            read_pointer_nx = read_pointer + ADDR_W'(1);
            state_nx        = FETCH;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    // busy covers the whole block including the cycle done is high
    busy_nx = (state_nx != IDLE) || (done_nx && (state != IDLE));
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      remaining    <= '0;
      read_pointer <= '0;
      opc_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      result       <= '0;
      res_addr     <= '0;
      res_opc      <= '0;
      res_valid    <= 1'b0;
      div_by_zero  <= 1'b0;
      illegal_op   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nx;
      remaining    <= remaining_nx;
      read_pointer <= read_pointer_nx;
      opc_q        <= opc_nx;
      op_a_q       <= op_a_nx;
      op_b_q       <= op_b_nx;
      result       <= result_nx;
      res_addr     <= res_addr_nx;
      res_opc      <= res_opc_nx;
      res_valid    <= res_valid_nx;
      div_by_zero  <= div_by_zero_nx;
      illegal_op   <= illegal_op_nx;
      busy         <= busy_nx;
      done         <= done_nx;
    end
  end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Directed self-checking bench for instr_exec_unit.
module tb_instr_exec_unit;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned OP_W   = 32;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                start;
  logic [ADDR_W-1:0]   start_addr;
  logic [ADDR_W:0]     count;
  logic [ADDR_W-1:0]   read_pointer;
  logic [4+2*OP_W-1:0] instruction_word;
  logic                res_valid;
  logic                res_ready;
  logic [2*OP_W-1:0]   result;
  logic [ADDR_W-1:0]   res_addr;
  logic [3:0]          res_opc;
  logic                div_by_zero;
  logic                illegal_op;
  logic                busy;
  logic                done;

  logic [4+2*OP_W-1:0] mem [32];

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int xfers  = 0;
  int dones  = 0;
  int x0, d0;

  instr_exec_unit #(.ADDR_W(ADDR_W), .OP_W(OP_W)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .start_addr       (start_addr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .result           (result),
    .res_addr         (res_addr),
    .res_opc          (res_opc),
    .div_by_zero      (div_by_zero),
    .illegal_op       (illegal_op),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  // combinational instruction register model
  assign instruction_word = mem[read_pointer];

  // count transfers and done pulses
  always @(posedge clk) begin
    if (reset_n && res_valid && res_ready) xfers <= xfers + 1;
    if (reset_n && done) dones <= dones + 1;
  end

  function automatic logic [4+2*OP_W-1:0] mk(input logic [3:0] opc,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    return {opc, a, b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_result(input string tag, input logic [63:0] exp_res,
                               input logic [4:0] exp_addr, input logic [3:0] exp_opc,
                               input logic exp_dz, input logic exp_ill);
    for (int i = 0; i < 8 && res_valid !== 1'b1; i++) @(negedge clk);
    chk({tag, ".valid"},  64'(res_valid), 64'd1);
    chk({tag, ".result"}, result, exp_res);
    chk({tag, ".addr"},   64'(res_addr), 64'(exp_addr));
    chk({tag, ".rp"},     64'(read_pointer), 64'(exp_addr));
    chk({tag, ".opc"},    64'(res_opc), 64'(exp_opc));
    chk({tag, ".dz"},     64'(div_by_zero), 64'(exp_dz));
    chk({tag, ".ill"},    64'(illegal_op), 64'(exp_ill));
    @(negedge clk);
    chk({tag, ".taken"},  64'(res_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[0]  = mk(4'd3, 32'd5, 32'd3);
    mem[1]  = mk(4'd4, -32'sd4, 32'd6);
    mem[2]  = mk(4'd5, -32'sd7, 32'd9);
    reset_n    = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    count      = '0;
    res_ready  = 1'b0;

    // reset values
    @(negedge clk);
    chk("rst.valid", 64'(res_valid), 64'd0);
    chk("rst.busy",  64'(busy), 64'd0);
    chk("rst.done",  64'(done), 64'd0);
    chk("rst.rp",    64'(read_pointer), 64'd0);
    chk("rst.result", result, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // block of three with back-pressure on the first result
    x0 = xfers; d0 = dones;
    start = 1'b1; start_addr = 5'd0; count = 6'd3;
    @(negedge clk);
    start = 1'b0;
    chk("t1.busy", 64'(busy), 64'd1);
    chk("t1.rp0",  64'(read_pointer), 64'd0);
    chk("t1.v1",   64'(res_valid), 64'd0);
    @(negedge clk);
    chk("t1.v2",   64'(res_valid), 64'd0);
    @(negedge clk);
    chk("t1.lat_valid", 64'(res_valid), 64'd1);
    chk("t1.r0",   result, 64'd8);
    chk("t1.a0",   64'(res_addr), 64'd0);
    chk("t1.o0",   64'(res_opc), 64'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.valid", 64'(res_valid), 64'd1);
      chk("bp.result", result, 64'd8);
      chk("bp.addr", 64'(res_addr), 64'd0);
      chk("bp.rp",   64'(read_pointer), 64'd0);
    end
    chk("bp.noxfer", 64'(xfers - x0), 64'd0);
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp.taken", 64'(res_valid), 64'd0);
    chk("bp.xfer",  64'(xfers - x0), 64'd1);
    expect_result("t1.r1", 64'(-10), 5'd1, 4'd4, 1'b0, 1'b0);
    expect_result("t1.r2", 64'(-63), 5'd2, 4'd5, 1'b0, 1'b0);
    chk("t1.done",  64'(done), 64'd1);
    chk("t1.busyd", 64'(busy), 64'd1);
    @(negedge clk);
    chk("t1.done_off", 64'(done), 64'd0);
    chk("t1.busy_off", 64'(busy), 64'd0);
    chk("t1.xfers", 64'(xfers - x0), 64'd3);
    chk("t1.dones", 64'(dones - d0), 64'd1);

    // wrap 30,31,0,1 with a start issued while busy
    mem[30] = mk(4'd1, 32'd11, 32'd99);
    mem[31] = mk(4'd2, 32'd0, -32'sd2);
    mem[0]  = mk(4'd0, 32'd9, 32'd9);
    mem[1]  = mk(4'd3, -32'sd1, -32'sd1);
    x0 = xfers; d0 = dones;
    start = 1'b1; start_addr = 5'd30; count = 6'd4;
    @(negedge clk);
    chk("t3.rp", 64'(read_pointer), 64'd30);
    start_addr = 5'd5; count = 6'd2;
    @(negedge clk);
    start = 1'b0;
    expect_result("t3.r30", 64'd11,   5'd30, 4'd1, 1'b0, 1'b0);
    expect_result("t3.r31", 64'(-2),  5'd31, 4'd2, 1'b0, 1'b0);
    expect_result("t3.r0",  64'd0,    5'd0,  4'd0, 1'b0, 1'b0);
    expect_result("t3.r1",  64'(-2),  5'd1,  4'd3, 1'b0, 1'b0);
    chk("t3.done", 64'(done), 64'd1);
    repeat (4) @(negedge clk);
    chk("t3.xfers", 64'(xfers - x0), 64'd4);
    chk("t3.dones", 64'(dones - d0), 64'd1);
    chk("t3.idle_valid", 64'(res_valid), 64'd0);
    chk("t3.idle_busy",  64'(busy), 64'd0);

    // divide / modulo / illegal opcode
    mem[4] = mk(4'd6, 32'd7, 32'd0);
    mem[5] = mk(4'd7, -32'sd7, 32'd0);
    mem[6] = mk(4'd6, -32'sd7, 32'd2);
    mem[7] = mk(4'd7, -32'sd7, 32'd2);
    mem[8] = mk(4'd12, 32'd5, 32'd5);
    mem[9] = mk(4'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    start = 1'b1; start_addr = 5'd4; count = 6'd6;
    @(negedge clk);
    start = 1'b0;
    expect_result("t4.div0", 64'd0,  5'd4, 4'd6,  1'b1, 1'b0);
    expect_result("t4.mod0", 64'd0,  5'd5, 4'd7,  1'b1, 1'b0);
    expect_result("t4.div",  64'(-3), 5'd6, 4'd6, 1'b0, 1'b0);
    expect_result("t4.mod",  64'(-1), 5'd7, 4'd7, 1'b0, 1'b0);
    expect_result("t4.ill",  64'd0,  5'd8, 4'd12, 1'b0, 1'b1);
    expect_result("t4.minneg", 64'h0000_0000_8000_0000, 5'd9, 4'd6, 1'b0, 1'b0);
    chk("t4.done", 64'(done), 64'd1);
    @(negedge clk);

    // zero-count start
    x0 = xfers; d0 = dones;
    start = 1'b1; start_addr = 5'd0; count = 6'd0;
    @(negedge clk);
    start = 1'b0;
    chk("t5.done",  64'(done), 64'd1);
    chk("t5.busy",  64'(busy), 64'd0);
    chk("t5.valid", 64'(res_valid), 64'd0);
    @(negedge clk);
    chk("t5.done_off", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    chk("t5.noxfer", 64'(xfers - x0), 64'd0);
    chk("t5.dones",  64'(dones - d0), 64'd1);

    // asynchronous reset while a result is pending
    res_ready = 1'b0;
    start = 1'b1; start_addr = 5'd2; count = 6'd2;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8 && res_valid !== 1'b1; i++) @(negedge clk);
    chk("t6.pending", 64'(res_valid), 64'd1);
    chk("t6.presult", result, 64'(-63));
    #2 reset_n = 1'b0;
    #1;
    chk("t6.valid",  64'(res_valid), 64'd0);
    chk("t6.result", result, 64'd0);
    chk("t6.addr",   64'(res_addr), 64'd0);
    chk("t6.opc",    64'(res_opc), 64'd0);
    chk("t6.busy",   64'(busy), 64'd0);
    chk("t6.rp",     64'(read_pointer), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    d0 = dones;
    res_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6.nodone", 64'(dones - d0), 64'd0);
    chk("t6.idle_valid", 64'(res_valid), 64'd0);
    chk("t6.idle_busy",  64'(busy), 64'd0);

    // unit accepts a new block after reset
    start = 1'b1; start_addr = 5'd2; count = 6'd1;
    @(negedge clk);
    start = 1'b0;
    expect_result("t6.rerun", 64'(-63), 5'd2, 4'd5, 1'b0, 1'b0);
    chk("t6.rerun_done", 64'(done), 64'd1);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
